// File: rtl/and_output_capture.sv
// Capture stage behind the AND gate: samples y into a small first-word
// fall-through FIFO, with an optional change-only capture mode and sticky
// overflow / saturating drop statistics.
module and_output_capture #(
    parameter int AND_INPUTS_WIDTH  = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int CAPTURE_ON_CHANGE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AND_INPUTS_WIDTH-1:0]   y,
    input  logic                          capture_en,
    input  logic                          clear_stats,
    output logic [AND_INPUTS_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [AND_INPUTS_WIDTH-1:0]  y_prev_q;
    logic [AND_INPUTS_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [AND_INPUTS_WIDTH-1:0]  out_data_q, out_data_d;
    logic                         out_valid_q;
    logic                         overflow_q, overflow_d;
    logic [7:0]                   drop_count_q, drop_count_d;

    logic push;
    logic pop;
    logic full;
    logic do_write;
    logic drop;

    // Capture FSM: first enabled cycle always captures, later ones may filter on change
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_en) begin
                    push    = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else begin
                    push = (CAPTURE_ON_CHANGE == 0) || (y != y_prev_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control: pointer/count update and next head value
    always_comb begin
        full     = (count_q == FULL_COUNT);
        pop      = out_valid_q & out_ready;
        do_write = push & (~full | pop);
        drop     = push & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;

        count_d = count_q;
        case ({do_write, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head is registered: when the new head is the entry being written
        // this cycle, take it straight from y since mem is not yet updated.
        out_data_d = out_data_q;
        if (count_d != '0) begin
            if (do_write && (wr_ptr_q == rd_ptr_d)) out_data_d = y;
            else                                     out_data_d = mem_q[rd_ptr_d];
        end
    end

    // Statistics: clear has priority over a same-cycle drop
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_stats) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 1'b1;
        end
    end

    // State, pointers, head and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            y_prev_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            y_prev_q     <= y;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= (count_d != '0);
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // FIFO storage; reset only moves pointers, contents need no clearing
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= y;
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_and_output_capture.sv
// Bench for and_output_capture: two instances (change-only and every-cycle
// capture) share inputs and are compared each cycle with a queue model.
module tb_and_output_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y;
    logic       capture_en;
    logic       clear_stats;
    logic       out_ready;

    logic [7:0] od  [2];
    logic       ov  [2];
    logic [2:0] fc  [2];
    logic       ovf [2];
    logic [7:0] dc  [2];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] mq [2][$];
    logic [7:0] m_data [2];
    logic       m_ovf  [2];
    int         m_drop [2];
    logic [7:0] m_yprev;
    logic       m_prev_en;

    always #5 clk = ~clk;

    and_output_capture #(.AND_INPUTS_WIDTH(8), .FIFO_DEPTH(4), .CAPTURE_ON_CHANGE(1)) u0 (
        .clk(clk), .rst(rst), .y(y), .capture_en(capture_en), .clear_stats(clear_stats),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .fifo_count(fc[0]),
        .overflow(ovf[0]), .drop_count(dc[0])
    );

    and_output_capture #(.AND_INPUTS_WIDTH(8), .FIFO_DEPTH(4), .CAPTURE_ON_CHANGE(0)) u1 (
        .clk(clk), .rst(rst), .y(y), .capture_en(capture_en), .clear_stats(clear_stats),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .fifo_count(fc[1]),
        .overflow(ovf[1]), .drop_count(dc[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    // Capture happens on the first enabled cycle, or later when every-cycle
    // mode is set or y has changed since the previous cycle.
    task automatic model_step();
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                m_data[k] = 8'h00;
                m_ovf[k]  = 1'b0;
                m_drop[k] = 0;
            end
            m_yprev   = 8'h00;
            m_prev_en = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit cap;
                bit dropped;
                cap = capture_en && (!m_prev_en || k == 1 || y != m_yprev);
                dropped = 1'b0;
                if (out_ready && mq[k].size() > 0) void'(mq[k].pop_front());
                if (cap) begin
                    if (mq[k].size() < 4) mq[k].push_back(y);
                    else dropped = 1'b1;
                end
                if (clear_stats) begin
                    m_ovf[k]  = 1'b0;
                    m_drop[k] = 0;
                end else if (dropped) begin
                    m_ovf[k] = 1'b1;
                    if (m_drop[k] < 255) m_drop[k]++;
                end
                if (mq[k].size() > 0) m_data[k] = mq[k][0];
            end
            m_yprev   = y;
            m_prev_en = capture_en;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("out_valid",  k, 32'(ov[k]),  32'(mq[k].size() > 0));
            chk("out_data",   k, 32'(od[k]),  32'(m_data[k]));
            chk("fifo_count", k, 32'(fc[k]),  32'(mq[k].size()));
            chk("overflow",   k, 32'(ovf[k]), 32'(m_ovf[k]));
            chk("drop_count", k, 32'(dc[k]),  32'(m_drop[k]));
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] yv, input logic en,
                         input logic rdy, input logic clr);
        rst = r; y = yv; capture_en = en; out_ready = rdy; clear_stats = clr;
    endtask

    initial begin
        logic [7:0] seq2 [6];
        seq2 = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'hF0};
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 8'h00; m_ovf[k] = 1'b0; m_drop[k] = 0;
        end
        m_yprev = 8'h00; m_prev_en = 1'b0;

        // Reset with inputs active
        drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_count", 0, 32'(fc[0]), 32'd0);
        chk("reset_valid", 1, 32'(ov[1]), 32'd0);

        // Change-only capture, then drain in order
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            y = seq2[i];
            tick();
            if (i == 0) chk("first_latency", 0, 32'(ov[0]), 32'd1);
        end
        chk("change_count", 0, 32'(fc[0]), 32'd3);
        capture_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drained", 0, 32'(ov[0]), 32'd0);
        chk("hold_data", 0, 32'(od[0]), 32'h0F0);

        // Overflow and clear
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("ovf_count", 1, 32'(fc[1]), 32'd4);
        chk("ovf_drops", 1, 32'(dc[1]), 32'd3);
        chk("ovf_flag",  1, 32'(ovf[1]), 32'd1);
        capture_en = 1'b0; clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_drops", 1, 32'(dc[1]), 32'd0);
        // Drop and clear in the same cycle: clear wins
        capture_en = 1'b1; clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear_wins", 1, 32'(dc[1]), 32'd0);

        // Full with simultaneous push and pop
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            y = 8'(8'h10 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y = 8'(8'h20 + i);
            tick();
        end
        chk("full_pp_count", 0, 32'(fc[0]), 32'd4);
        chk("full_pp_drops", 1, 32'(dc[1]), 32'd0);

        // Drop counter saturation
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 304; i++) begin
            y = 8'(i + 1);
            tick();
        end
        chk("sat_drops", 0, 32'(dc[0]), 32'd255);
        chk("sat_drops", 1, 32'(dc[1]), 32'd255);

        // Reset mid-stream flushes; first sample afterwards is unconditional
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        tick(); y = 8'h22; tick(); y = 8'h33; tick();
        chk("pre_flush", 0, 32'(fc[0]), 32'd3);
        rst = 1'b1;
        tick();
        chk("flushed", 0, 32'(fc[0]), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst_cap", 0, 32'(fc[0]), 32'd1);
        chk("post_rst_data", 0, 32'(od[0]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            y           = 8'($urandom_range(0, 3) * 8'h41);
            capture_en  = ($urandom_range(0, 3) != 0);
            out_ready   = $urandom_range(0, 1) == 1;
            clear_stats = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
